// File: rtl/count_seg_display.sv
// Counter sampler with 15->0 roll-over tally, driving a 2-digit multiplexed common-anode hex display.
// Optional macro COUNT_SEG_BLANK_EN blanks digit 1 when the roll-over tally is zero.
module count_seg_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int DIV_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count_in,
    input  logic       clr,
    output logic       wrap_pulse,
    output logic [3:0] wrap_cnt,
    output logic [1:0] an,
    output logic [6:0] seg
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [3:0]       r_count_q;
    logic [3:0]       r_wrap_cnt;
    logic             r_wrap_pulse;
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_digit_sel;
    logic [1:0]       r_an;
    logic [6:0]       r_seg;

    logic             w_wrap;
    logic             w_div_last;
    logic             w_blank;
    logic [3:0]       w_hex_val;
    logic [6:0]       w_next_seg;

    // Active-low hex font, segment order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign w_wrap     = (r_count_q == 4'hF) && (count_in == 4'h0);
    assign w_div_last = (r_div_cnt == DIV_LAST);

    always_comb begin
        w_blank   = 1'b0;
        w_hex_val = r_digit_sel ? r_wrap_cnt : r_count_q;
`ifdef COUNT_SEG_BLANK_EN
        w_blank   = r_digit_sel && (r_wrap_cnt == 4'h0);
`else
        w_blank   = 1'b0;
`endif
        w_next_seg = w_blank ? 7'b1111111 : hex7(w_hex_val);
    end

    // clr wins over a simultaneous wrap for the tally, but the strobe still fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count_q    <= 4'h0;
            r_wrap_cnt   <= 4'h0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_count_q    <= count_in;
            r_wrap_pulse <= w_wrap;
            if (clr)
                r_wrap_cnt <= 4'h0;
            else if (w_wrap)
                r_wrap_cnt <= r_wrap_cnt + 4'h1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt   <= '0;
            r_digit_sel <= 1'b0;
        end else begin
            if (w_div_last) begin
                r_div_cnt   <= '0;
                r_digit_sel <= ~r_digit_sel;
            end else begin
                r_div_cnt   <= r_div_cnt + 1'b1;
            end
        end
    end

    // Pins are registered from the pre-edge digit select, so they lag it by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= 2'b11;
            r_seg <= 7'b1111111;
        end else begin
            r_an  <= r_digit_sel ? 2'b01 : 2'b10;
            r_seg <= w_next_seg;
        end
    end

    assign wrap_pulse = r_wrap_pulse;
    assign wrap_cnt   = r_wrap_cnt;
    assign an         = r_an;
    assign seg        = r_seg;

endmodule

// File: tb/tb_count_seg_display.sv
// Self-checking bench for count_seg_display with a behavioural model of tally and scan.
// Honours COUNT_SEG_BLANK_EN to pick the expected digit-1 behaviour.
module tb_count_seg_display;

    localparam int RDIV = 4;

    logic       clk;
    logic       rst;
    logic [3:0] count_in;
    logic       clr;
    logic       wrap_pulse;
    logic [3:0] wrap_cnt;
    logic [1:0] an;
    logic [6:0] seg;

    int compared;
    int mismatched;

    // model state
    int mPrev;
    int mTally;
    int mPulse;
    int mEdges;
    int expAn;
    int expSeg;

    logic [6:0] font [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

`ifdef COUNT_SEG_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    count_seg_display #(.REFRESH_DIV(RDIV), .DIV_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .count_in   (count_in),
        .clr        (clr),
        .wrap_pulse (wrap_pulse),
        .wrap_cnt   (wrap_cnt),
        .an         (an),
        .seg        (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPrev  = 0;
        mTally = 0;
        mPulse = 0;
        mEdges = 0;
    endtask

    // One clock: drive on the falling edge, advance the model at the rising edge, check 1 ns later.
    task automatic applyStimulus(input int v, input bit c);
        int digit;
        @(negedge clk);
        count_in = 4'(v);
        clr      = c;
        @(posedge clk);
        mEdges++;
        digit  = ((mEdges - 1) / RDIV) % 2;
        expAn  = (digit == 1) ? 2 'b01 : 2'b10;
        if (digit == 1)
            expSeg = (BLANK && mTally == 0) ? 7'h7F : int'(font[mTally]);
        else
            expSeg = int'(font[mPrev]);
        mPulse = (mPrev == 15 && v == 0) ? 1 : 0;
        if (c)
            mTally = 0;
        else if (mPulse == 1)
            mTally = (mTally + 1) % 16;
        mPrev = v;
        #1;
        checkOutput("wrap_pulse", int'(wrap_pulse), mPulse);
        checkOutput("wrap_cnt",   int'(wrap_cnt),   mTally);
        checkOutput("an",         int'(an),         expAn);
        checkOutput("seg",        int'(seg),        expSeg);
    endtask

    // Asynchronous reset pulse placed between edges, with immediate output checks.
    task automatic midCycleReset();
        #2;
        rst      = 1'b1;
        count_in = 4'h5;
        #1;
        checkOutput("rst_an",    int'(an),         2'b11);
        checkOutput("rst_seg",   int'(seg),        7'h7F);
        checkOutput("rst_wrap",  int'(wrap_cnt),   0);
        checkOutput("rst_pulse", int'(wrap_pulse), 0);
        modelReset();
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        clr        = 1'b0;
        count_in   = 4'h0;
        modelReset();
        #12;
        checkOutput("init_an",  int'(an),  2'b11);
        checkOutput("init_seg", int'(seg), 7'h7F);
        rst = 1'b0;

        // a few edges then a mid-cycle reset
        applyStimulus(3, 1'b0);
        applyStimulus(4, 1'b0);
        midCycleReset();
        applyStimulus(1, 1'b0);
        checkOutput("first_an", int'(an), 2'b10);
        applyStimulus(1, 1'b0);
        checkOutput("second_seg", int'(seg), 7'b1111001);

        // 16 full counter rounds plus a final 0 -> tally returns to 0
        pulses = 0;
        for (int r = 0; r < 16; r++) begin
            for (int v = 0; v < 16; v++) begin
                applyStimulus(v, 1'b0);
                pulses += int'(wrap_pulse);
            end
        end
        applyStimulus(0, 1'b0);
        pulses += int'(wrap_pulse);
        checkOutput("wrap_mod16", int'(wrap_cnt), 0);
        checkOutput("pulse_total", pulses, 16);

        // non-wrap transitions and held F
        applyStimulus(7, 1'b0);
        applyStimulus(0, 1'b0);
        applyStimulus(0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(15, 1'b0);
        applyStimulus(0, 1'b0);
        checkOutput("held_f_wrap", int'(wrap_cnt), 1);

        // raise tally to 3, then clr together with a wrap
        for (int i = 0; i < 2; i++) begin
            applyStimulus(15, 1'b0);
            applyStimulus(0, 1'b0);
        end
        applyStimulus(15, 1'b0);
        applyStimulus(0, 1'b1);
        checkOutput("clr_pulse", int'(wrap_pulse), 1);
        checkOutput("clr_wrap",  int'(wrap_cnt),   0);

        // scan with tally zero (blanking case) and a held count
        midCycleReset();
        for (int i = 0; i < 16; i++) applyStimulus(2, 1'b0);

        // scan with count 8 and tally A
        midCycleReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(15, 1'b0);
            applyStimulus(0, 1'b0);
        end
        for (int i = 0; i < 16; i++) applyStimulus(8, 1'b0);

        // randomized traffic with biased roll-overs and occasional clr
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3, 0) == 0) begin
                applyStimulus(15, 1'b0);
                applyStimulus(0, ($urandom_range(7, 0) == 0));
            end else begin
                applyStimulus(int'($urandom_range(15, 0)), ($urandom_range(19, 0) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
